// File: rtl/histo_pkg.sv
// Shared constants and FSM encoding for the ping-pong luminance histogram.
package histo_pkg;
  localparam int BIN_W        = 8;
  localparam int CNT_W        = 20;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [CNT_W-1:0] SAT_VAL = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;
endpackage

// File: rtl/histo_bank_ram.sv
// One histogram bank: simple dual-port RAM, registered read, read-during-write returns old data.
module histo_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 20
) (
  input  logic          iClk,
  input  logic          iWrEn,
  input  logic [AW-1:0] iWrAddr,
  input  logic [DW-1:0] iWrData,
  input  logic [AW-1:0] iRdAddr,
  output logic [DW-1:0] oRdData
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge iClk) begin
    if (iWrEn) r_mem[iWrAddr] <= iWrData;
    r_rd_data <= r_mem[iRdAddr];
  end

  assign oRdData = r_rd_data;
endmodule

// File: rtl/histogram_frame_controller.sv
// Ping-pong 256-bin histogram: one bank accumulates the live frame, the other feeds the display.
module histogram_frame_controller #(
  parameter int BIN_W = histo_pkg::BIN_W,
  parameter int CNT_W = histo_pkg::CNT_W,
  parameter logic [CNT_W-1:0] CLR_VAL = '0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFrameStart,
  input  logic             iFrameEnd,
  input  logic             iPixValid,
  input  logic [BIN_W-1:0] iPixel,
  input  logic [BIN_W-1:0] iRdAddr,
  output logic [CNT_W-1:0] oRdData,
  output logic [CNT_W-1:0] oMaxValue,
  output logic             oBankSel,
  output logic             oFrameDone,
  output logic             oBusy,
  output logic             oDropped,
  output logic             oSaturated
);
  import histo_pkg::*;

  localparam logic [CNT_W-1:0] L_SAT       = {CNT_W{1'b1}};
  localparam logic [BIN_W-1:0] L_LAST_ADDR = {BIN_W{1'b1}};
  localparam logic [1:0]       L_DRAIN_END = 2'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_drain_cnt;
  logic [BIN_W-1:0] r_clr_addr;
  logic             r_clr_both, r_start_pend;
  logic             r_bank_sel, r_rd_sel, r_rd_vld;
  logic [CNT_W-1:0] r_max, r_run_max;
  logic             r_done, r_dropped, r_sat;

  logic             r_s1_vld, r_s2_vld, r_s3_vld;
  logic [BIN_W-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
  logic [CNT_W-1:0] r_s2_val, r_s3_val;

  logic             w_swap, w_disp_next, w_clearing, w_s1_clip;
  logic [CNT_W-1:0] w_acc_rd, w_base, w_s1_val;
  logic [CNT_W-1:0] w_rd_data [2];

  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_swap      = (r_state == ST_DRAIN) && (r_drain_cnt == L_DRAIN_END);
  // The display read issued in the swap cycle already targets the new display bank.
  assign w_disp_next = r_bank_sel ^ w_swap;
  assign w_acc_rd    = r_bank_sel ? w_rd_data[0] : w_rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic             w_is_accum, w_we;
      logic [BIN_W-1:0] w_rd_addr, w_wr_addr;
      logic [CNT_W-1:0] w_wr_data;

      assign w_is_accum = (r_bank_sel != 1'(gi));
      assign w_rd_addr  = (w_disp_next == 1'(gi)) ? iRdAddr : iPixel;
      assign w_we       = (w_clearing && (r_clr_both || w_is_accum)) || (r_s2_vld && w_is_accum);
      assign w_wr_addr  = w_clearing ? r_clr_addr : r_s2_addr;
      assign w_wr_data  = w_clearing ? CLR_VAL : r_s2_val;

      histo_bank_ram #(.AW(BIN_W), .DW(CNT_W)) u_bank (
        .iClk    (iClk),
        .iWrEn   (w_we),
        .iWrAddr (w_wr_addr),
        .iWrData (w_wr_data),
        .iRdAddr (w_rd_addr),
        .oRdData (w_rd_data[gi])
      );
    end
  endgenerate

  // RAM read misses the write in flight (s2) and the one just committed (s3); newest wins.
  always_comb begin
    w_base = w_acc_rd;
    if (r_s3_vld && r_s3_addr == r_s1_addr) w_base = r_s3_val;
    if (r_s2_vld && r_s2_addr == r_s1_addr) w_base = r_s2_val;
  end

  assign w_s1_clip = (w_base == L_SAT);
  assign w_s1_val  = w_s1_clip ? L_SAT : w_base + 1'b1;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_s1_vld  <= iPixValid && (r_state == ST_ACCUM);
      r_s1_addr <= iPixel;
      r_s2_vld  <= r_s1_vld;
      r_s2_addr <= r_s1_addr;
      r_s2_val  <= w_s1_val;
      r_s3_vld  <= r_s2_vld;
      r_s3_addr <= r_s2_addr;
      r_s3_val  <= r_s2_val;
      r_rd_vld  <= 1'b1;
      r_rd_sel  <= w_disp_next;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= ST_CLEAR;
      r_clr_addr   <= '0;
      r_clr_both   <= 1'b1;
      r_start_pend <= 1'b0;
      r_drain_cnt  <= '0;
      r_bank_sel   <= 1'b0;
      r_max        <= '0;
      r_run_max    <= '0;
      r_done       <= 1'b0;
      r_dropped    <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (iPixValid && (r_state == ST_DRAIN || r_state == ST_CLEAR)) r_dropped <= 1'b1;
      if (r_s1_vld && w_s1_clip) r_sat <= 1'b1;
      if (r_s2_vld && r_s2_val > r_run_max) r_run_max <= r_s2_val;
      case (r_state)
        ST_IDLE: begin
          if (iFrameStart) begin
            r_state   <= ST_ACCUM;
            r_dropped <= 1'b0;
            r_sat     <= 1'b0;
            r_run_max <= '0;
          end
        end
        ST_ACCUM: begin
          // A restart only resets the max; bins keep accumulating.
          if (iFrameStart) r_run_max <= '0;
          if (iFrameEnd) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_swap) begin
            r_bank_sel   <= ~r_bank_sel;
            r_max        <= r_run_max;
            r_done       <= 1'b1;
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_start_pend <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (iFrameStart) r_start_pend <= 1'b1;
          if (r_clr_addr == L_LAST_ADDR) begin
            r_clr_both   <= 1'b0;
            r_start_pend <= 1'b0;
            if (r_start_pend || iFrameStart) begin
              r_state   <= ST_ACCUM;
              r_sat     <= 1'b0;
              r_run_max <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oRdData    = r_rd_vld ? w_rd_data[r_rd_sel] : '0;
  assign oMaxValue  = r_max;
  assign oBankSel   = r_bank_sel;
  assign oFrameDone = r_done;
  assign oBusy      = (r_state == ST_DRAIN) || (r_state == ST_CLEAR);
  assign oDropped   = r_dropped;
  assign oSaturated = r_sat;
endmodule

// File: tb/tb_histogram_frame_controller.sv
// Directed bench for the ping-pong histogram; counters are 12 bits so saturation is reachable quickly.
module tb_histogram_frame_controller;
  localparam int BW = 8;
  localparam int CW = 12;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [BW-1:0] pixel = '0, rd_addr = '0;
  logic [CW-1:0] rd_data, max_value;
  logic          bank_sel, frame_done, busy, dropped, saturated;

  int n_vec = 0;
  int n_err = 0;
  int last_done_rd = 0;
  int v, nz;

  histogram_frame_controller #(.BIN_W(BW), .CNT_W(CW), .CLR_VAL('0)) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iFrameStart (frame_start),
    .iFrameEnd   (frame_end),
    .iPixValid   (pix_valid),
    .iPixel      (pixel),
    .iRdAddr     (rd_addr),
    .oRdData     (rd_data),
    .oMaxValue   (max_value),
    .oBankSel    (bank_sel),
    .oFrameDone  (frame_done),
    .oBusy       (busy),
    .oDropped    (dropped),
    .oSaturated  (saturated)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    tick(); tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_max", max_value, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 1);
    check("rst_dropped", dropped, 0);
    check("rst_saturated", saturated, 0);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    while (busy && w < 400) begin tick(); w++; end
    check(tag, busy, 0);
  endtask

  task automatic start_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic send_pix(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pixel = BW'(val); tick();
    end
    pix_valid = 1'b0;
  endtask

  // Returns one cycle after the frame-done pulse (CLEAR cycle 1).
  task automatic end_frame(input bit with_pix, input int val);
    int w = 0;
    frame_end = 1'b1; pix_valid = with_pix; pixel = BW'(val);
    tick();
    frame_end = 1'b0; pix_valid = 1'b0;
    while (!frame_done && w < 20) begin tick(); w++; end
    check("done_latency", w, 3);
    last_done_rd = rd_data;
    tick();
    check("done_pulse_width", frame_done, 0);
  endtask

  task automatic read_bin(input int a, output int d);
    rd_addr = BW'(a); tick(); d = rd_data;
  endtask

  task automatic count_nonzero(output int n);
    n = 0;
    for (int a = 0; a < (1 << BW); a++) begin
      rd_addr = BW'(a); tick();
      if (rd_data != 0) n++;
    end
  endtask

  initial begin
    // Reset clears both banks
    do_reset();
    wait_idle("t1_idle_after_reset");
    count_nonzero(nz); check("t1_bank0_nonzero", nz, 0);
    start_frame();
    end_frame(0, 0);
    check("t1_bank_sel", bank_sel, 1);
    check("t1_max_empty", max_value, 0);
    count_nonzero(nz); check("t1_bank1_nonzero", nz, 0);
    wait_idle("t1_idle");

    // 1000 back-to-back pixels of 37, swap-cycle read of bin 37
    start_frame();
    send_pix(37, 1000);
    rd_addr = 8'd37;
    end_frame(0, 0);
    check("t2_swap_read_bin37", last_done_rd, 1000);
    check("t2_bank_sel", bank_sel, 0);
    check("t2_max", max_value, 1000);
    check("t2_saturated", saturated, 0);
    check("t2_dropped", dropped, 0);
    count_nonzero(nz); check("t2_nonzero_bins", nz, 1);
    wait_idle("t2_idle");

    // Forwarding hazards, last pixel coincides with iFrameEnd
    start_frame();
    send_pix(5, 2); send_pix(6, 1); send_pix(5, 1); send_pix(6, 1);
    end_frame(1, 6);
    check("t3_bank_sel", bank_sel, 1);
    check("t3_max", max_value, 3);
    read_bin(5, v); check("t3_bin5", v, 3);
    read_bin(6, v); check("t3_bin6", v, 3);
    read_bin(37, v); check("t3_bin37", v, 0);
    wait_idle("t3_idle");

    // Restart mid-frame: max restarts, bins keep counting
    start_frame();
    send_pix(10, 5);
    tick(); tick(); tick();
    start_frame();
    send_pix(11, 2);
    end_frame(0, 0);
    check("t4_bank_sel", bank_sel, 0);
    check("t4_max_after_restart", max_value, 2);
    read_bin(10, v); check("t4_bin10", v, 5);
    read_bin(11, v); check("t4_bin11", v, 2);
    count_nonzero(nz); check("t4_nonzero_bins", nz, 2);
    wait_idle("t4_idle");

    // Saturation of bin 200
    start_frame();
    send_pix(200, SAT + 2);
    rd_addr = 8'd200;
    end_frame(0, 0);
    check("t5_swap_read_bin200", last_done_rd, SAT);
    check("t5_bank_sel", bank_sel, 1);
    check("t5_saturated", saturated, 1);
    check("t5_max", max_value, SAT);
    check("t5_dropped", dropped, 0);

    // Start 10 cycles into CLEAR; pixels stream through the rest of CLEAR
    repeat (9) tick();
    for (int c = 10; c <= 275; c++) begin
      frame_start = (c == 10);
      pix_valid = 1'b1; pixel = 8'd77; rd_addr = 8'd200;
      if (c == 20)  check("t6_display_during_clear", rd_data, SAT);
      if (c == 30)  check("t6_dropped_in_clear", dropped, 1);
      if (c == 255) check("t6_busy_last_clear", busy, 1);
      if (c == 255) check("t6_sat_before_accum", saturated, 1);
      if (c == 256) check("t6_busy_accum_entry", busy, 0);
      if (c == 256) check("t6_dropped_kept", dropped, 1);
      if (c == 256) check("t6_sat_cleared", saturated, 0);
      tick();
    end
    frame_start = 1'b0; pix_valid = 1'b0;
    rd_addr = 8'd77;
    end_frame(0, 0);
    check("t6_bin77", last_done_rd, 20);
    check("t6_bank_sel", bank_sel, 0);
    check("t6_max", max_value, 20);
    check("t6_dropped_end", dropped, 1);
    read_bin(10, v); check("t6_bin10_cleared", v, 0);
    wait_idle("t6_idle");

    // Reset mid-ACCUM wipes everything
    start_frame();
    send_pix(50, 30);
    pix_valid = 1'b1; pixel = 8'd50;
    do_reset();
    pix_valid = 1'b0;
    wait_idle("t7_idle_after_reset");
    read_bin(77, v); check("t7_bin77_gone", v, 0);
    count_nonzero(nz); check("t7_bank0_nonzero", nz, 0);
    start_frame();
    end_frame(0, 0);
    check("t7_bank_sel", bank_sel, 1);
    check("t7_max_empty", max_value, 0);
    count_nonzero(nz); check("t7_bank1_nonzero", nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/histogram_frame_controller.md
Name: histogram_frame_controller

Overview:
- Builds the per-frame 256-bin luminance histogram that the on-screen histogram display consumes.
- Owns two histogram banks in a ping-pong arrangement: one accumulates the current camera frame, the other is frozen and served to the display read port.
- At frame end it drains the accumulate pipeline, swaps banks, publishes the frame's peak bin count, then clears the bank it will fill next.

Parameters:
- BIN_W, 8, bin address width (2^BIN_W bins)
- CNT_W, 20, bin counter width; also the max-value width
- CLR_VAL, 0, value written to every bin during clear

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous active-high reset
- iFrameStart  in  1  one-cycle pulse, first pixel of a camera frame follows
- iFrameEnd  in  1  one-cycle pulse, after the last pixel of the frame
- iPixValid  in  1  iPixel is valid this cycle
- iPixel  in  BIN_W  pixel intensity = bin index
- iRdAddr  in  BIN_W  display-side bin address
- oRdData  out  CNT_W  display bank count for iRdAddr, 1-cycle latency
- oMaxValue  out  CNT_W  peak bin count of the displayed frame
- oBankSel  out  1  index of the bank currently displayed
- oFrameDone  out  1  one-cycle pulse when a swap completes
- oBusy  out  1  high in DRAIN and CLEAR
- oDropped  out  1  sticky per frame: pixel(s) discarded
- oSaturated  out  1  sticky per frame: some bin clipped at 2^CNT_W-1

Behaviour:
- Interface: one clock iClk; reset iRst is synchronous and active-high.
- Reset values:
  - FSM enters CLEAR targeting both banks, so both banks read 0 afterwards.
  - oRdData=0, oMaxValue=0, oBankSel=0, oFrameDone=0, oBusy=1, oDropped=0, oSaturated=0.
- Reset has priority over every other input in every state and aborts any operation in progress.
- FSM states: IDLE, ACCUM, DRAIN, CLEAR.
  - IDLE: on iFrameStart go to ACCUM; clear oDropped and oSaturated; clear the running max.
  - ACCUM: each iPixValid performs a read-modify-write of bin iPixel in the accumulate bank.
    - 3-stage pipeline: read, increment, write; sustains 1 pixel/cycle.
    - A hit on an in-flight bin forwards the newest value. Back-to-back identical pixels must count exactly.
    - Increment saturates at 2^CNT_W-1 and sets oSaturated.
    - Running max = max(running max, written value).
    - On iFrameEnd go to DRAIN. A pixel valid in the same cycle as iFrameEnd is counted.
  - DRAIN: lasts exactly 3 cycles while the pipeline empties; iPixValid is dropped and sets oDropped. Then, in a single cycle:
    - toggle oBankSel;
    - oMaxValue <= running max;
    - pulse oFrameDone;
    - go to CLEAR.
  - CLEAR: writes CLR_VAL to the new accumulate bank, one address per cycle, addresses 0..2^BIN_W-1 (256 cycles). Then go to IDLE, or go directly to ACCUM if a start is pending.
- Start during CLEAR:
  - iFrameStart seen in CLEAR sets a pending-start flag.
  - Pixels arriving while in CLEAR are discarded and set oDropped.
  - oDropped is cleared on ACCUM entry only when that entry is not from a pending start. A pending start keeps oDropped set.
- Other input events:
  - iFrameStart in ACCUM restarts the frame: running max is cleared, but bins are not cleared. This is intended, and a bench checks that accumulation continues.
  - iFrameEnd outside ACCUM is ignored.
  - iPixValid in IDLE is ignored and does not set oDropped.
- Display read port:
  - Always reads the bank selected by oBankSel.
  - Registered with 1-cycle latency.
  - Never stalls and never conflicts with accumulation, because it reads the other bank.
  - On a swap, the read issued in the swap cycle returns data from the new display bank.
- oBusy = (state==DRAIN || state==CLEAR).
- Arithmetic: counts are unsigned CNT_W; the comparator for running max is unsigned.

Decomposition:
- Shared package histo_pkg holds:
  - BIN_W and CNT_W defaults;
  - the state encoding (IDLE=0, ACCUM=1, DRAIN=2, CLEAR=3);
  - the constant DRAIN_CYCLES=3;
  - the constant SAT_VAL = {CNT_W{1'b1}}.
- One sub-module, histo_bank_ram:
  - simple dual-port RAM of 2^BIN_W x CNT_W;
  - one synchronous read port, one write port, read-during-write returns old data;
  - instantiated twice.
- Forwarding, the FSM and the max tracker stay in the top module.

Test Plan:
- Reset, then wait 256 cycles, then read all bins of both banks (toggle banks with an empty frame) -> all 0; oMaxValue=0 after the empty frame.
- Frame of 1000 pixels, all value 37, back-to-back; then iFrameEnd -> after DRAIN: oFrameDone pulses once, oBankSel=1, iRdAddr=37 returns 1000 next cycle, every other bin returns 0, oMaxValue=1000.
- Alternating pixel pattern 5,5,6,5,6,6 (forwarding hazards) -> bin5=3, bin6=3, oMaxValue=3.
- Force bin 200 to 2^20-1 via 2^20+2 pixels (or a preload hook) -> bin reads 1048575, oSaturated=1, no wrap to 0.
- iFrameStart 10 cycles into CLEAR, followed by pixels -> pixels in the remaining CLEAR cycles are discarded; oDropped=1; ACCUM begins the cycle after the 256th clear write; later pixels counted.
- Assert iRst mid-ACCUM, then follow with a 256-cycle CLEAR -> all outputs at reset values, both banks 0, previously accumulated counts gone.
